// File: rtl/cpcs_tx_sched.sv
// cpcs_tx_sched - transmit symbol scheduler placed directly ahead of the
// CorePCS 8b/10b encoder.
//
// Merges a valid/ready byte stream with control symbols. The link idles
// with /I/ ordered sets (K28.5 then D16.2). Each frame is sent as
// SOF K27.7, data, then EOF K29.7 or error-end K30.7. K23.7 fills any
// cycle with no data and pads odd-length frames, so that every K28.5
// starts on an even symbol position. The block also enforces the minimum
// inter-frame gap and the maximum frame length, and it schedules
// forced-RD- K28.5 symbols for disparity resync.
//
// Ports:
//   CLK, RST              clock; asynchronous active-high reset
//   EN                    frame enable, sampled only at /I/ boundaries
//   DISP_RESYNC           pulse; force RD- on the next K28.5
//   DIN_DATA/VALID/LAST   frame byte stream in
//   DIN_READY             byte accepted this cycle (state-decoded only)
//   TX_D/K/FORCE_DISP/DISP_SEL  registered encoder inputs
//   FRAME_DONE/FRAME_ERR  one-cycle pulses, aligned with EOF/EEOF on TX
//   TX_BUSY               high while TX carries SOF..PAD
module cpcs_tx_sched #(
  parameter int MIN_IDLE  = 2,
  parameter int MAX_FRAME = 1024
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic       EN,
  input  logic       DISP_RESYNC,
  input  logic [7:0] DIN_DATA,
  input  logic       DIN_VALID,
  input  logic       DIN_LAST,
  output logic       DIN_READY,
  output logic [7:0] TX_D,
  output logic       TX_K,
  output logic       TX_FORCE_DISP,
  output logic       TX_DISP_SEL,
  output logic       FRAME_DONE,
  output logic       FRAME_ERR,
  output logic       TX_BUSY
);

  localparam logic [2:0] ST_IDLE_K = 3'd0;
  localparam logic [2:0] ST_IDLE_D = 3'd1;
  localparam logic [2:0] ST_SOF    = 3'd2;
  localparam logic [2:0] ST_DATA   = 3'd3;
  localparam logic [2:0] ST_EOF    = 3'd4;
  localparam logic [2:0] ST_EEOF   = 3'd5;
  localparam logic [2:0] ST_PAD    = 3'd6;

  localparam logic [3:0]  MIN_IDLE_C  = 4'(MIN_IDLE);
  localparam logic [15:0] MAX_FRAME_C = 16'(MAX_FRAME);

  localparam logic [7:0] SYM_K28_5 = 8'hBC;
  localparam logic [7:0] SYM_D16_2 = 8'h50;
  localparam logic [7:0] SYM_SOF   = 8'hFB;
  localparam logic [7:0] SYM_EOF   = 8'hFD;
  localparam logic [7:0] SYM_FILL  = 8'hF7;
  localparam logic [7:0] SYM_EEOF  = 8'hFE;

  logic [2:0]  state_reg, state_next;
  logic [3:0]  idle_cnt_reg, idle_cnt_next, idle_inc;
  logic [15:0] len_cnt_reg, len_cnt_next, len_inc;
  logic        drain_reg, drain_next;
  logic        resync_pend_reg, resync_pend_next;
  logic        parity_reg, parity_next;
  logic [7:0]  sym_d;
  logic        sym_k, sym_force, done_next, err_next, busy_next;
  logic        hs;

  // While draining a truncated frame, the idle states keep accepting
  // bytes so that the upstream source can finish its frame.
  assign DIN_READY = (state_reg == ST_DATA) |
                     (drain_reg & ((state_reg == ST_IDLE_K) | (state_reg == ST_IDLE_D)));
  assign hs = DIN_VALID & DIN_READY;

  assign idle_inc = (idle_cnt_reg >= MIN_IDLE_C) ? idle_cnt_reg : idle_cnt_reg + 4'd1;
  assign len_inc  = len_cnt_reg + 16'd1;

  always_comb begin
    state_next       = state_reg;
    idle_cnt_next    = idle_cnt_reg;
    len_cnt_next     = len_cnt_reg;
    drain_next       = drain_reg;
    parity_next      = parity_reg;
    // A new request is OR-ed in ahead of servicing, so a pulse that
    // coincides with the serviced K28.5 still survives to the next one.
    resync_pend_next = resync_pend_reg | DISP_RESYNC;
    sym_d            = SYM_K28_5;
    sym_k            = 1'b1;
    sym_force        = 1'b0;
    done_next        = 1'b0;
    err_next         = 1'b0;

    // The drain flag can only be set in DATA, so clearing it here never
    // conflicts with the EEOF branch below.
    if (drain_reg & hs & DIN_LAST)
      drain_next = 1'b0;

    case (state_reg)
      ST_IDLE_K: begin
        if (resync_pend_reg) begin
          sym_force        = 1'b1;
          resync_pend_next = DISP_RESYNC;
        end
        state_next = ST_IDLE_D;
      end
      ST_IDLE_D: begin
        sym_d         = SYM_D16_2;
        sym_k         = 1'b0;
        idle_cnt_next = idle_inc;
        // Using drain_reg (and not drain_next) keeps SOF off the cycle in
        // which the final drained byte is accepted.
        if (EN & DIN_VALID & ~drain_reg & (idle_inc >= MIN_IDLE_C))
          state_next = ST_SOF;
        else
          state_next = ST_IDLE_K;
      end
      ST_SOF: begin
        sym_d        = SYM_SOF;
        len_cnt_next = 16'd0;
        parity_next  = 1'b1;
        state_next   = ST_DATA;
      end
      ST_DATA: begin
        parity_next = ~parity_reg;
        if (hs) begin
          sym_d        = DIN_DATA;
          sym_k        = 1'b0;
          len_cnt_next = len_inc;
          if (DIN_LAST) begin
            state_next = ST_EOF;
          end else if (len_inc == MAX_FRAME_C) begin
            state_next = ST_EEOF;
            drain_next = 1'b1;
          end
        end else begin
          sym_d = SYM_FILL;
        end
      end
      ST_EOF, ST_EEOF: begin
        sym_d         = (state_reg == ST_EOF) ? SYM_EOF : SYM_EEOF;
        done_next     = (state_reg == ST_EOF);
        err_next      = (state_reg == ST_EEOF);
        parity_next   = ~parity_reg;
        idle_cnt_next = 4'd0;
        // An odd count so far (after this symbol) needs one pad symbol
        // to bring the next K28.5 onto an even position.
        state_next    = parity_reg ? ST_IDLE_K : ST_PAD;
      end
      ST_PAD: begin
        sym_d      = SYM_FILL;
        state_next = ST_IDLE_K;
      end
      default: begin
        state_next = ST_IDLE_K;
      end
    endcase

    busy_next = (state_reg == ST_SOF)  | (state_reg == ST_DATA) |
                (state_reg == ST_EOF)  | (state_reg == ST_EEOF) |
                (state_reg == ST_PAD);
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_reg       <= ST_IDLE_K;
      idle_cnt_reg    <= 4'd0;
      len_cnt_reg     <= 16'd0;
      drain_reg       <= 1'b0;
      resync_pend_reg <= 1'b1;
      parity_reg      <= 1'b0;
      TX_D            <= SYM_K28_5;
      TX_K            <= 1'b1;
      TX_FORCE_DISP   <= 1'b0;
      TX_DISP_SEL     <= 1'b0;
      FRAME_DONE      <= 1'b0;
      FRAME_ERR       <= 1'b0;
      TX_BUSY         <= 1'b0;
    end else begin
      state_reg       <= state_next;
      idle_cnt_reg    <= idle_cnt_next;
      len_cnt_reg     <= len_cnt_next;
      drain_reg       <= drain_next;
      resync_pend_reg <= resync_pend_next;
      parity_reg      <= parity_next;
      TX_D            <= sym_d;
      TX_K            <= sym_k;
      TX_FORCE_DISP   <= sym_force;
      TX_DISP_SEL     <= 1'b0;  // forced disparity is always RD-
      FRAME_DONE      <= done_next;
      FRAME_ERR       <= err_next;
      TX_BUSY         <= busy_next;
    end
  end

endmodule
